// File: rtl/int_issue_exec_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | int_issue_exec_unit_if                                             |
// | Issue-queue handshake and CDB request/broadcast bundle.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface int_issue_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              issueque_ready;
    logic [2:0]        issue_opcode;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic [DATA_W-1:0] issue_rs1_data;
    logic [DATA_W-1:0] issue_rs2_data;
    logic              issueblk_done;
    logic              cdb_req;
    logic              cdb_grant;
    logic              CDB_valid;
    logic [TAG_W-1:0]  CDB_tag;
    logic [DATA_W-1:0] CDB_data;

    // Queue / CDB arbiter side.
    modport master (
        output issueque_ready, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data,
        output cdb_grant,
        input  issueblk_done, cdb_req, CDB_valid, CDB_tag, CDB_data
    );

    // Execution unit side.
    modport slave (
        input  issueque_ready, issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data,
        input  cdb_grant,
        output issueblk_done, cdb_req, CDB_valid, CDB_tag, CDB_data
    );
endinterface
`default_nettype wire

// File: rtl/int_issue_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | int_issue_exec_unit                                                |
// | Single-issue integer ALU/multiply unit with CDB req/grant output.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module int_issue_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 4
) (
    input  wire                   clk,
    input  wire                   reset_n,
    int_issue_exec_unit_if.slave  bus
);

    localparam int c_CNT_W = ($clog2(MUL_LAT - 1) < 1) ? 1 : $clog2(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_LAT - 2);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLL = 3'b101;
    localparam logic [2:0] c_OP_SRL = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_WAIT_CDB = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_mul_a;
    logic [DATA_W-1:0]  r_mul_b;
    logic [DATA_W-1:0]  r_res_data;
    logic [TAG_W-1:0]   r_res_tag;
    logic               r_cdb_valid;
    logic [TAG_W-1:0]   r_cdb_tag;
    logic [DATA_W-1:0]  r_cdb_data;

    logic [DATA_W-1:0]  w_alu;
    logic [DATA_W-1:0]  w_prod;
    logic [4:0]         w_shamt;

    assign w_shamt = bus.issue_rs2_data[4:0];
    assign w_prod  = r_mul_a * r_mul_b;

    always_comb begin
        w_alu = '0;
        case (bus.issue_opcode)
            c_OP_ADD: w_alu = bus.issue_rs1_data + bus.issue_rs2_data;
            c_OP_SUB: w_alu = bus.issue_rs1_data - bus.issue_rs2_data;
            c_OP_AND: w_alu = bus.issue_rs1_data & bus.issue_rs2_data;
            c_OP_OR:  w_alu = bus.issue_rs1_data | bus.issue_rs2_data;
            c_OP_XOR: w_alu = bus.issue_rs1_data ^ bus.issue_rs2_data;
            c_OP_SLL: w_alu = bus.issue_rs1_data << w_shamt;
            c_OP_SRL: w_alu = bus.issue_rs1_data >> w_shamt;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else begin
            r_cdb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.issueque_ready) begin
                        r_res_tag <= bus.issue_rd_tag;
                        if (bus.issue_opcode == c_OP_MUL) begin
                            r_mul_a <= bus.issue_rs1_data;
                            r_mul_b <= bus.issue_rs2_data;
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= S_EXEC;
                        end else begin
                            r_res_data <= w_alu;
                            r_state    <= S_WAIT_CDB;
                        end
                    end
                end
                S_EXEC: begin
                    // Counter runs MUL_LAT-1 cycles so the request lands MUL_LAT-1 edges after transfer.
                    if (r_cnt == '0) begin
                        r_res_data <= w_prod;
                        r_state    <= S_WAIT_CDB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAIT_CDB: begin
                    if (bus.cdb_grant) begin
                        r_cdb_tag   <= r_res_tag;
                        r_cdb_data  <= r_res_data;
                        r_cdb_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.issueblk_done = (r_state == S_IDLE);
    assign bus.cdb_req       = (r_state == S_WAIT_CDB);
    assign bus.CDB_valid     = r_cdb_valid;
    assign bus.CDB_tag       = r_cdb_tag;
    assign bus.CDB_data      = r_cdb_data;

endmodule
`default_nettype wire

// File: tb/tb_int_issue_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_int_issue_exec_unit                                             |
// | Vector table, corner sequences and randomized model-based checks.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_int_issue_exec_unit;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 6;
    localparam int MUL_LAT = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int_issue_exec_unit_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus();

    logic grant_tie   = 1'b1;
    logic grant_force = 1'b0;
    assign bus.cdb_grant = grant_tie ? bus.cdb_req : grant_force;

    int_issue_exec_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]        op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] exp;
        int                lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.issueque_ready = rdy;
        bus.issue_opcode   = op;
        bus.issue_rd_tag   = tag;
        bus.issue_rs1_data = a;
        bus.issue_rs2_data = b;
    endtask

    // Behavioural result: plain arithmetic, product taken from a full-width multiply.
    function automatic logic [DATA_W-1:0] ref_result(input logic [2:0] op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        int sh;
        sh = int'(b % 32);
        p  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return a >> sh;
            default: return p[DATA_W-1:0];
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit seen;
        check($sformatf("v%0d_idle_before", idx), 64'(bus.issueblk_done), 64'd1);
        drive(1'b1, v.op, v.tag, v.a, v.b);
        tick();
        drive(1'b0, 3'($urandom), TAG_W'($urandom), $urandom, $urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            if (bus.CDB_valid) seen = 1'b1;
            else check($sformatf("v%0d_busy", idx), 64'(bus.issueblk_done), 64'd0);
        end
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d_tag", idx), 64'(bus.CDB_tag), 64'(v.tag));
        check($sformatf("v%0d_data", idx), 64'(bus.CDB_data), 64'(v.exp));
        check($sformatf("v%0d_done_on_valid", idx), 64'(bus.issueblk_done), 64'd1);
        tick();
        check($sformatf("v%0d_valid_one_cycle", idx), 64'(bus.CDB_valid), 64'd0);
        check($sformatf("v%0d_tag_hold", idx), 64'(bus.CDB_tag), 64'(v.tag));
        check($sformatf("v%0d_data_hold", idx), 64'(bus.CDB_data), 64'(v.exp));
    endtask

    vec_t vecs[12];

    // Random-phase model state
    bit                m_inflight, m_req_now, vexp, idle_before;
    int                m_req_edge;
    logic [TAG_W-1:0]  m_tag, m_last_tag;
    logic [DATA_W-1:0] m_data, m_last_data;

    function automatic logic [DATA_W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 1;
            2:       return '1;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, req_cnt;
        bit seen;
        logic              r_rdy, r_g;
        logic [2:0]        r_op;
        logic [TAG_W-1:0]  r_tag;
        logic [DATA_W-1:0] r_a, r_b;

        vecs[0]  = '{3'd0, 6'd17, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1};
        vecs[1]  = '{3'd1, 6'd1,  32'd0,         32'd1,        32'hFFFF_FFFF, 1};
        vecs[2]  = '{3'd2, 6'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1};
        vecs[3]  = '{3'd3, 6'd3,  32'hF0F0_0000, 32'h0F0F_0001, 32'hFFFF_0001, 1};
        vecs[4]  = '{3'd4, 6'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1};
        vecs[5]  = '{3'd5, 6'd5,  32'd1,         32'h25,       32'h0000_0020, 1};
        vecs[6]  = '{3'd6, 6'd6,  32'h8000_0000, 32'd31,       32'h0000_0001, 1};
        vecs[7]  = '{3'd7, 6'd7,  32'd1000,      32'd3000,     32'd3000000,   MUL_LAT};
        vecs[8]  = '{3'd7, 6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT};
        vecs[9]  = '{3'd0, 6'd9,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1};
        vecs[10] = '{3'd6, 6'd10, 32'hFFFF_FFFF, 32'h20,       32'hFFFF_FFFF, 1};
        vecs[11] = '{3'd5, 6'd11, 32'd3,         32'd31,       32'h8000_0000, 1};

        drive(1'b0, 3'd0, '0, '0, '0);

        // Asynchronous reset with no clock edge yet
        #1 reset_n = 1'b0;
        #1;
        check("rst_done",  64'(bus.issueblk_done), 64'd1);
        check("rst_req",   64'(bus.cdb_req),       64'd0);
        check("rst_valid", 64'(bus.CDB_valid),     64'd0);
        check("rst_tag",   64'(bus.CDB_tag),       64'd0);
        check("rst_data",  64'(bus.CDB_data),      64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // MUL with three withheld grant cycles; a pending ADD is held on the queue throughout
        grant_tie   = 1'b0;
        grant_force = 1'b0;
        drive(1'b1, 3'd7, 6'd5, 32'd1000, 32'd3000);
        tick();
        drive(1'b1, 3'd0, 6'd9, 32'd40, 32'd2);
        req_cnt = 0;
        lat     = 0;
        seen    = 1'b0;
        while (!seen && lat < 30) begin
            tick();
            lat++;
            if (bus.CDB_valid) seen = 1'b1;
            else check("stall_busy", 64'(bus.issueblk_done), 64'd0);
            if (bus.cdb_req) req_cnt++;
            grant_force = (req_cnt >= 4);
        end
        check("stall_latency",    64'(lat),             64'(MUL_LAT + 3));
        check("stall_req_cycles", 64'(req_cnt),         64'd4);
        check("stall_tag",        64'(bus.CDB_tag),     64'd5);
        check("stall_data",       64'(bus.CDB_data),    64'd3000000);
        check("stall_done",       64'(bus.issueblk_done), 64'd1);
        grant_force = 1'b0;
        grant_tie   = 1'b1;
        tick();
        drive(1'b0, 3'd0, '0, '0, '0);
        check("held_add_no_dup", 64'(bus.CDB_valid),     64'd0);
        check("held_add_busy",   64'(bus.issueblk_done), 64'd0);
        tick();
        check("held_add_valid", 64'(bus.CDB_valid), 64'd1);
        check("held_add_tag",   64'(bus.CDB_tag),   64'd9);
        check("held_add_data",  64'(bus.CDB_data),  64'd42);
        tick();

        // Back-to-back ALU issue
        drive(1'b1, 3'd4, 6'd11, 32'h0000_FF00, 32'h0F0F_0F0F);
        tick();
        drive(1'b1, 3'd3, 6'd12, 32'h1200_0000, 32'h0000_0034);
        tick();
        check("b2b_first_valid", 64'(bus.CDB_valid),     64'd1);
        check("b2b_first_tag",   64'(bus.CDB_tag),       64'd11);
        check("b2b_first_data",  64'(bus.CDB_data),      64'h0F0F_F00F);
        check("b2b_first_done",  64'(bus.issueblk_done), 64'd1);
        tick();
        drive(1'b0, 3'd0, '0, '0, '0);
        check("b2b_gap_valid", 64'(bus.CDB_valid),     64'd0);
        check("b2b_gap_busy",  64'(bus.issueblk_done), 64'd0);
        tick();
        check("b2b_second_valid", 64'(bus.CDB_valid), 64'd1);
        check("b2b_second_tag",   64'(bus.CDB_tag),   64'd12);
        check("b2b_second_data",  64'(bus.CDB_data),  64'h1200_0034);
        tick();
        check("b2b_after_valid", 64'(bus.CDB_valid),     64'd0);
        check("b2b_after_done",  64'(bus.issueblk_done), 64'd1);

        // Reset in the middle of a multiply
        drive(1'b1, 3'd7, 6'd33, 32'd7, 32'd9);
        tick();
        drive(1'b0, 3'd0, '0, '0, '0);
        tick();
        check("midmul_busy", 64'(bus.issueblk_done), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        check("midmul_rst_done",  64'(bus.issueblk_done), 64'd1);
        check("midmul_rst_req",   64'(bus.cdb_req),       64'd0);
        check("midmul_rst_valid", 64'(bus.CDB_valid),     64'd0);
        check("midmul_rst_tag",   64'(bus.CDB_tag),       64'd0);
        check("midmul_rst_data",  64'(bus.CDB_data),      64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midmul_no_bcast", 64'(bus.CDB_valid),     64'd0);
            check("midmul_idle",     64'(bus.issueblk_done), 64'd1);
        end
        run_vec('{3'd0, 6'd20, 32'd5, 32'd6, 32'd11, 1}, 100);

        // Randomized run against the transaction-level model
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        grant_tie   = 1'b0;
        m_inflight  = 1'b0;
        m_req_now   = 1'b0;
        m_req_edge  = 0;
        m_tag       = '0;
        m_data      = '0;
        m_last_tag  = '0;
        m_last_data = '0;
        for (int k = 1; k <= 3000; k++) begin
            r_rdy = ($urandom_range(0, 9) < 7);
            r_op  = 3'($urandom);
            r_tag = TAG_W'($urandom);
            r_a   = pick_operand();
            r_b   = pick_operand();
            r_g   = ($urandom_range(0, 2) != 0);
            drive(r_rdy, r_op, r_tag, r_a, r_b);
            grant_force = r_g;
            tick();
            idle_before = !m_inflight;
            vexp        = 1'b0;
            if (m_inflight && m_req_now && r_g) begin
                vexp        = 1'b1;
                m_last_tag  = m_tag;
                m_last_data = m_data;
                m_inflight  = 1'b0;
            end else if (idle_before && r_rdy) begin
                m_inflight = 1'b1;
                m_tag      = r_tag;
                m_data     = ref_result(r_op, r_a, r_b);
                m_req_edge = k + ((r_op == 3'd7) ? MUL_LAT - 1 : 0);
            end
            m_req_now = m_inflight && (k >= m_req_edge);
            check("rand_done",  64'(bus.issueblk_done), 64'(!m_inflight));
            check("rand_req",   64'(bus.cdb_req),       64'(m_req_now));
            check("rand_valid", 64'(bus.CDB_valid),     64'(vexp));
            check("rand_tag",   64'(bus.CDB_tag),       64'(m_last_tag));
            check("rand_data",  64'(bus.CDB_data),      64'(m_last_data));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_issue_exec_unit.md
# int_issue_exec_unit

Integer issue/execute block on the consumer side of the integer issue queue. It takes the oldest ready instruction when `issueque_ready` is high, signalling acceptance on `issueblk_done`. It executes the instruction as a single-cycle ALU op or a multi-cycle multiply, arbitrates for the common data bus with a req/grant handshake, and broadcasts the result. The queue snoops that broadcast as `CDB_tag`/`CDB_valid` to wake dependent operands.

## Interface
- `DATA_W`, 32, operand/result width
- `TAG_W`, 6, physical register tag width
- `MUL_LAT`, 4, multiply latency in cycles (≥2)

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `issueque_ready` in 1: queue holds a ready instruction; the operand inputs below are valid.
- `issue_opcode` in 3: operation.
- `issue_rd_tag` in TAG_W: destination tag.
- `issue_rs1_data` in DATA_W: operand A.
- `issue_rs2_data` in DATA_W: operand B.
- `issueblk_done` out 1: unit idle and accepting; drives queue shift.
- `cdb_req` out 1: request for the CDB.
- `cdb_grant` in 1: CDB arbiter grant, combinational from `cdb_req`.
- `CDB_valid` out 1: one-cycle broadcast strobe.
- `CDB_tag` out TAG_W: broadcast destination tag.
- `CDB_data` out DATA_W: broadcast result.

## Operation
- **Opcodes:**
  - 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR.
  - 101 SLL by B[4:0], 110 SRL (logical) by B[4:0].
  - 111 MUL, low DATA_W bits of the unsigned product.
  - Add and sub wrap modulo 2^DATA_W with no flags.
- **States:** IDLE, EXEC, WAIT_CDB. A 2-bit binary encoding is sufficient.
- **Transfer:** a transfer occurs on a rising edge where `issueque_ready && issueblk_done`. Opcode, tag and operands are captured only at transfer and never sampled otherwise.
- **IDLE:**
  - `issueblk_done`=1, combinationally equal to (state==IDLE).
  - On transfer with opcode≠111: compute the ALU result, register it with the tag, go to WAIT_CDB.
  - On transfer with MUL: load the latency counter with MUL_LAT−2, go to EXEC.
- **EXEC:**
  - The counter decrements each cycle.
  - When the counter is 0, register the product and tag and go to WAIT_CDB.
  - Internal multiplier pipelining is free, provided the externally visible latency matches Timing.
- **WAIT_CDB:**
  - `cdb_req`=1.
  - On an edge with `cdb_req && cdb_grant`: load `CDB_tag`/`CDB_data` from the result registers, set `CDB_valid`=1 for the following cycle only, go to IDLE.
  - Without grant, stay in WAIT_CDB with the result held stable for as many cycles as it takes.
- **Grant outside WAIT_CDB:** ignored.
- **`issueque_ready` outside IDLE:** ignored. No transfer occurs because `issueblk_done`=0.
- **Back-to-back issue:** the cycle in which `CDB_valid`=1 is an IDLE cycle, so a new transfer may occur in that same cycle.
- **CDB outputs between broadcasts:** `CDB_tag` and `CDB_data` hold the last broadcast value while `CDB_valid`=0.
- **Reset:** `reset_n` low at any time, including mid-EXEC or mid-WAIT_CDB, forces an immediate return to IDLE. The in-flight instruction is discarded and no broadcast is made for it.
- **Reset values:**
  - `issueblk_done`=1 (IDLE).
  - `cdb_req`=0, `CDB_valid`=0.
  - `CDB_tag`=0, `CDB_data`=0.
  - Counter and result registers = 0.

## Timing
- **ALU op:** transfer at edge T. `cdb_req` is high in the cycle after T. With immediate grant, `CDB_valid` is high in the cycle after edge T+1, i.e. 2 cycles from transfer to broadcast.
- **MUL:** `cdb_req` rises MUL_LAT cycles after the transfer edge. With immediate grant, `CDB_valid` follows one cycle later. For MUL_LAT=4 that is 5 cycles from transfer to broadcast.
- **Grant stall:** each cycle of withheld grant adds exactly one cycle of latency.
- **`issueblk_done`:** low from the cycle after transfer until the cycle `CDB_valid` is high, inclusive of neither.
- **Throughput:** at most one instruction in flight.
  - ALU: 1 transfer per 2 cycles with immediate grant.
  - MUL: 1 per MUL_LAT+1 cycles.

## Test plan
- **Reset:** assert `reset_n`=0 mid-cycle without a clock edge. All outputs take their reset values immediately (asynchronous), with `issueblk_done`=1.
- **ADD, immediate grant:** `issueque_ready`=1, op=000, tag=6'd17, A=32'hFFFF_FFFF, B=1, `cdb_grant` tied to `cdb_req`. Expect `CDB_valid` high exactly one cycle, 2 cycles after transfer, with `CDB_tag`=17 and `CDB_data`=0.
- **MUL with stalled grant:** op=111, A=1000, B=3000, MUL_LAT=4, `cdb_grant`=0 for 3 cycles after `cdb_req` rises. Expect `cdb_req` held 4 cycles, `CDB_data`=3,000,000 and `CDB_valid` 8 cycles after transfer. `issueblk_done`=0 throughout, and `issueque_ready` held high causes no extra transfer.
- **Shifts and logic:** SLL A=1, B=32'h25 → `CDB_data`=32'h20 (only B[4:0]=5 is used). SRL A=32'h8000_0000, B=31 → 1. SUB A=0, B=1 → 32'hFFFF_FFFF.
- **Back-to-back transfer:** `issueque_ready` held high with a second ALU op presented. The second transfer occurs in the same cycle `CDB_valid` is high for the first. Broadcasts arrive 2 cycles apart with their own tags, and no instruction is lost or duplicated.
- **Reset mid-MUL:** pulse `reset_n` low during EXEC. No `CDB_valid` is ever produced for that tag, the unit is in IDLE after release, and a following ADD completes normally.
